// File: rtl/sll_pkg.sv
// Shared types and sizing for the iterative logical left shifter.
package sll_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SHW    = 5;
    localparam int unsigned STAGEW = $clog2(SHW);
    // Upper operand bits that must all be zero for an in-range shift.
    localparam int unsigned OVW    = WIDTH - SHW;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/sll_stage.sv
// One conditional shift stage: shifts by 2**k when enabled, otherwise passes through.
module sll_stage
    import sll_pkg::*;
(
    input  logic [WIDTH-1:0]  acc_i,
    input  logic              en_i,
    input  logic [STAGEW-1:0] k_i,
    output logic [WIDTH-1:0]  acc_o
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = acc_i << (32'd1 << k_i);
        acc_o   = en_i ? shifted : acc_i;
    end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: one shift-amount bit per cycle, start/done handshake.
module sll_iter
    import sll_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic [STAGEW-1:0]   stage_q, stage_d;
    logic [SHW-1:0]      shamt_q, shamt_d;
    logic [WIDTH-1:0]    stage_out;
    logic                stage_en;

    assign stage_en = shamt_q[stage_q];

    sll_stage u_stage (
        .acc_i (acc_q),
        .en_i  (stage_en),
        .k_i   (stage_q),
        .acc_o (stage_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        stage_d = stage_q;
        shamt_d = shamt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    acc_d   = A;
                    shamt_d = B[SHW-1:0];
                    stage_d = '0;
                    // Any set bit above the stage range shifts everything out.
                    if (|B[WIDTH-1:SHW]) begin
                        res_d   = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                acc_d   = stage_out;
                stage_d = stage_q + STAGEW'(1);
                if (stage_q == STAGEW'(SHW - 1)) begin
                    res_d   = stage_out;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            res_q   <= '0;
            stage_q <= '0;
            shamt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            stage_q <= stage_d;
            shamt_q <= shamt_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign res  = res_q;

endmodule

// File: tb/tb_sll_iter.sv
// Directed self-checking bench for sll_iter.
module tb_sll_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int total;
    int bad;

    sll_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from IDLE (called at posedge+1); reports latency and observations.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output logic [31:0] r, output int nbusy, output bit res_moved);
        logic [31:0] r0;
        r0        = res;
        nbusy     = 0;
        lat       = -1;
        res_moved = 1'b0;
        r         = 32'hDEAD_BEEF;
        A         = a;
        B         = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                r   = res;
                break;
            end
            if (res !== r0) res_moved = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if (res !== 32'h0) begin bad++; $display("FAIL reset_res got=%h want=0", res); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, nb;
        logic [31:0] r;
        bit moved;
        issue(32'h0000_0001, 32'd5, lat, r, nb, moved);
        total++;
        if (lat !== 6) begin bad++; $display("FAIL basic_lat got=%0d want=6", lat); end
        total++;
        if (r !== 32'h0000_0020) begin bad++; $display("FAIL basic_res got=%h want=00000020", r); end
        total++;
        if (nb !== 5) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=5", nb); end
        total++;
        if (moved !== 1'b0) begin bad++; $display("FAIL basic_res_stable got=%b want=0", moved); end
    endtask

    task automatic test_patterns();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ve [4];
        int lat, nb;
        logic [31:0] r;
        bit moved;
        va[0] = 32'hF000_000F; vb[0] = 32'd31; ve[0] = 32'h8000_0000;
        va[1] = 32'hF000_000F; vb[1] = 32'd0;  ve[1] = 32'hF000_000F;
        va[2] = 32'h1234_5678; vb[2] = 32'd4;  ve[2] = 32'h2345_6780;
        va[3] = 32'hABCD_1234; vb[3] = 32'd16; ve[3] = 32'h1234_0000;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], lat, r, nb, moved);
            total++;
            if (r !== ve[i]) begin
                bad++;
                $display("FAIL pattern%0d_res got=%h want=%h", i, r, ve[i]);
            end
            total++;
            if (lat !== 6) begin bad++; $display("FAIL pattern%0d_lat got=%0d want=6", i, lat); end
        end
    endtask

    task automatic test_oversize();
        logic [31:0] vb [2];
        int lat, nb;
        logic [31:0] r;
        bit moved;
        vb[0] = 32'd32;
        vb[1] = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            // Leave a nonzero result behind so the zero is observable.
            issue(32'h0000_0003, 32'd2, lat, r, nb, moved);
            issue(32'hFFFF_FFFF, vb[i], lat, r, nb, moved);
            total++;
            if (r !== 32'h0) begin bad++; $display("FAIL oversize%0d_res got=%h want=0", i, r); end
            total++;
            if (lat !== 1) begin bad++; $display("FAIL oversize%0d_lat got=%0d want=1", i, lat); end
            total++;
            if (nb !== 0) begin bad++; $display("FAIL oversize%0d_busy got=%0d want=0", i, nb); end
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] r1, r2;
        lat1  = -1;
        lat2  = -1;
        r1    = 32'hDEAD_BEEF;
        r2    = 32'hDEAD_BEEF;
        A     = 32'd1;
        B     = 32'd1;
        start = 1'b1;
        @(posedge clk); #1;
        A = 32'd3;
        B = 32'd4;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin lat1 = k; r1 = res; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_restart busy=%b done=%b want busy=1 done=0", busy, done);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin lat2 = k; r2 = res; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        total++;
        if (lat1 !== 6 || r1 !== 32'h2) begin
            bad++;
            $display("FAIL b2b_first got lat=%0d res=%h want lat=6 res=00000002", lat1, r1);
        end
        total++;
        if (lat2 !== 6 || r2 !== 32'h30) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d res=%h want lat=6 res=00000030", lat2, r2);
        end
    endtask

    task automatic test_ignore_in_shift();
        int lat;
        logic [31:0] r;
        lat   = -1;
        r     = 32'hDEAD_BEEF;
        A     = 32'h0000_00FF;
        B     = 32'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        A     = 32'hFFFF_FFFF;
        B     = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 3; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin lat = k; r = res; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        total++;
        if (r !== 32'h0000_FF00) begin bad++; $display("FAIL ignore_res got=%h want=0000ff00", r); end
        total++;
        if (lat !== 6) begin bad++; $display("FAIL ignore_lat got=%0d want=6", lat); end
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat, nb;
        logic [31:0] r;
        bit moved;
        bit saw_done;
        saw_done = 1'b0;
        A        = 32'd1;
        B        = 32'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 32'h0) begin
            bad++;
            $display("FAIL midreset got busy=%b done=%b res=%h want 0 0 0", busy, done, res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=1 want=0"); end
        @(posedge clk); #1;
        issue(32'h0000_0007, 32'd2, lat, r, nb, moved);
        total++;
        if (r !== 32'h1C || lat !== 6) begin
            bad++;
            $display("FAIL midreset_after got lat=%0d res=%h want lat=6 res=0000001c", lat, r);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_patterns();
        test_oversize();
        test_back_to_back();
        test_ignore_in_shift();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
